// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches, buffers {inst, pc4}.
// Ack to out_valid is one cycle; a full queue drops imem_req; redirects flush and drop in-flight data.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        pcrst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      hold_addr_q, hold_addr_d;
   logic             drop_q, drop_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      inst_q [DEPTH];
   logic [31:0]      pc4_q  [DEPTH];

   logic xfer, push, pop;

   always_comb begin
      imem_req  = !pcrst && (drop_q || (count_q != FULL));
      imem_addr = drop_q ? hold_addr_q : fetch_pc_q;
      out_valid = !pcrst && (count_q != '0);
      out_inst  = inst_q[head_q];
      out_pc4   = pc4_q[head_q];
      xfer      = imem_req && imem_ack;
      push      = xfer && !drop_q && !redirect;
      pop       = out_valid && !stall && !redirect;
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      hold_addr_d = hold_addr_q;
      drop_d      = drop_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (redirect) begin
         // A request still waiting for its ack must complete at the old address, then be discarded.
         count_d     = '0;
         head_d      = '0;
         tail_d      = '0;
         fetch_pc_d  = redirect_pc & ~32'h3;
         drop_d      = imem_req && !imem_ack;
         hold_addr_d = imem_addr;
      end else begin
         if (xfer && drop_q) begin
            drop_d = 1'b0;
         end
         if (push) begin
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pcrst) begin
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= '0;
         drop_q      <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
         drop_q      <= drop_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_q[tail_q] <= imem_rdata;
         pc4_q[tail_q]  <= fetch_pc_q + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory returns addr ^ 32'hA5A50000, ack is driven per scenario.
module tb_fetch_queue;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        pcrst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc4;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;

   int errors = 0;
   int checks = 0;

   assign imem_rdata = imem_addr ^ K;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .pcrst(pcrst), .redirect(redirect), .redirect_pc(redirect_pc),
      .stall(stall), .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pcrst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      tick();
      pcrst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      pcrst = 1'b1;
      tick(); tick();
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_hold_req: got %b want 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
      pcrst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_rel_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_rel_addr: got %h want 00000000", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      do_reset();
      imem_ack = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b want 1", k, out_valid); end
         checks++; if (out_pc4 !== 32'(4*k)) begin errors++; $display("FAIL stream_pc4 c%0d: got %h want %h", k, out_pc4, 32'(4*k)); end
         checks++; if (out_inst !== (32'(4*(k-1)) ^ K)) begin errors++; $display("FAIL stream_inst c%0d: got %h want %h", k, out_inst, 32'(4*(k-1)) ^ K); end
         checks++; if (imem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_addr c%0d: got %h want %h", k, imem_addr, 32'(4*k)); end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      logic        exp_req;
      logic [31:0] exp_pc4;
      do_reset();
      imem_ack = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         stall = (c >= 2 && c <= 11);
         #1;
         exp_req = !(c >= 5 && c <= 12);
         exp_pc4 = (c == 1) ? 32'd4 : (c <= 12) ? 32'd8 : 32'(8 + 4*(c-12));
         checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL bp_req c%0d: got %b want %b", c, imem_req, exp_req); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
         checks++; if (out_pc4 !== exp_pc4) begin errors++; $display("FAIL bp_pc4 c%0d: got %h want %h", c, out_pc4, exp_pc4); end
         checks++; if (out_inst !== ((exp_pc4 - 32'd4) ^ K)) begin errors++; $display("FAIL bp_inst c%0d: got %h want %h", c, out_inst, (exp_pc4 - 32'd4) ^ K); end
      end
      imem_ack = 1'b0; stall = 1'b0;
   endtask

   task automatic test_redirect_ack();
      do_reset();
      imem_ack = 1'b1;
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 32'h103;
      #1;
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rda_addr8: got %h want 00000008", imem_addr); end
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rda_flush: got %b want 0", out_valid); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rda_addr: got %h want 00000100", imem_addr); end
      tick();
      imem_ack = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rda_valid: got %b want 1", out_valid); end
      checks++; if (out_pc4 !== 32'h104) begin errors++; $display("FAIL rda_pc4: got %h want 00000104", out_pc4); end
      checks++; if (out_inst !== (32'h100 ^ K)) begin errors++; $display("FAIL rda_inst: got %h want %h", out_inst, 32'h100 ^ K); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
      #1;
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rdw_c1_addr: got %h want 00000004", imem_addr); end
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdw_c2_valid: got %b want 0", out_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rdw_c2_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rdw_c2_addr: got %h want 00000004", imem_addr); end
      tick();
      imem_ack = 1'b1;
      #1;
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rdw_c3_addr: got %h want 00000004", imem_addr); end
      tick();
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      #1;
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rdw_c4_addr: got %h want 00000200", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdw_c4_dropped: got %b want 0", out_valid); end
      tick();
      redirect_pc = 32'h380;
      #1;
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rdw_c5_addr: got %h want 00000200", imem_addr); end
      tick();
      redirect = 1'b0; imem_ack = 1'b1;
      #1;
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rdw_c6_addr: got %h want 00000200", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdw_c6_valid: got %b want 0", out_valid); end
      tick();
      #1;
      checks++; if (imem_addr !== 32'h380) begin errors++; $display("FAIL rdw_c7_addr: got %h want 00000380", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdw_c7_valid: got %b want 0", out_valid); end
      tick();
      imem_ack = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rdw_c8_valid: got %b want 1", out_valid); end
      checks++; if (out_pc4 !== 32'h384) begin errors++; $display("FAIL rdw_c8_pc4: got %h want 00000384", out_pc4); end
      checks++; if (out_inst !== (32'h380 ^ K)) begin errors++; $display("FAIL rdw_c8_inst: got %h want %h", out_inst, 32'h380 ^ K); end
   endtask

   task automatic test_wrap();
      do_reset();
      imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush: got %b want 0", out_valid); end
      tick();
      imem_ack = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
      checks++; if (out_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", out_pc4); end
      checks++; if (out_inst !== (32'hFFFF_FFFC ^ K)) begin errors++; $display("FAIL wrap_inst: got %h want %h", out_inst, 32'hFFFF_FFFC ^ K); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_ack = 1'b1; stall = 1'b1;
      tick(); tick(); tick();
      imem_ack = 1'b0; pcrst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_full_valid: got %b want 0", out_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_full_req: got %b want 0", imem_req); end
      tick();
      pcrst = 1'b0; stall = 1'b0; imem_ack = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_rel_valid: got %b want 0", out_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_rel_addr: got %h want 00000000", imem_addr); end
      tick();
      imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
      #1;
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rm_pre_addr: got %h want 00000004", imem_addr); end
      tick();
      redirect = 1'b0; pcrst = 1'b1; imem_ack = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_drop_req: got %b want 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_drop_valid: got %b want 0", out_valid); end
      tick();
      pcrst = 1'b0; imem_ack = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_restart_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart_addr: got %h want 00000000", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_restart_valid: got %b want 0", out_valid); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_first_valid: got %b want 1", out_valid); end
      checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL rm_first_pc4: got %h want 00000004", out_pc4); end
      checks++; if (out_inst !== K) begin errors++; $display("FAIL rm_first_inst: got %h want %h", out_inst, K); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_ack();
      test_redirect_wait();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end for the 5-stage pipelined CPU. It sits between a wait-state-capable instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues word fetches over a req/ack interface. Fetched instructions are buffered together with their PC+4 so that hazard stalls and wait states are decoupled. Branch/jump redirects flush all wrong-path work.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
pcrst  input  1  synchronous active-high reset
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0
stall  input  1  IF/ID stall from hazard unit; head must not be consumed
out_valid  output  1  head entry valid
out_inst  output  32  head instruction
out_pc4  output  32  head instruction address + 4
imem_req  output  1  fetch request
imem_addr  output  32  fetch word address
imem_ack  input  1  transfer completes on an edge where imem_req & imem_ack
imem_rdata  input  32  instruction data, valid when imem_ack

Behaviour:
- State:
  - fetch_pc
  - circular queue of {inst, pc4} with head/tail/count (0..DEPTH)
  - drop flag and hold_addr register.
- Reset (pcrst=1 at an edge):
  - count=0, drop=0, fetch_pc=RESET_PC.
  - Outputs the following cycle: out_valid=0, imem_req=1, imem_addr=RESET_PC.
  - While pcrst is high: imem_req=0, out_valid=0.
  - An in-flight memory transaction is abandoned. Memory shares pcrst.
- imem_req = !pcrst && (drop || count<DEPTH), using registered count. A pop in the same cycle does not free space early.
- imem_addr = drop ? hold_addr : fetch_pc.
  - Once raised, imem_req stays high with a stable address until ack.
- Accept (req&ack, no redirect, drop=0):
  - Push {imem_rdata, fetch_pc+4}.
  - fetch_pc += 4, mod 2^32.
- Drop (req&ack with drop=1):
  - Data discarded; drop<=0.
  - fetch_pc is unchanged; it already holds the redirect target.
- Pop: out_valid & !stall advances head at the edge. Push and pop in the same cycle leave count unchanged.
- out_valid = count!=0. out_inst/out_pc4 are driven from the head entry.
- Latency and throughput:
  - Ack to out_valid is 1 cycle; there is no bypass.
  - With zero-wait memory and no stall, throughput is 1 instruction/cycle.
- Redirect has priority over push/pop in its cycle:
  - count<=0 and fetch_pc<=redirect_pc&~3.
  - If req&!ack that cycle: drop<=1 and hold_addr<=current imem_addr.
  - If req&ack that cycle: the returning data is discarded and no hold is needed.
  - Redirect while drop=1: only fetch_pc is updated; drop stays 1.
  - out_valid=0 in the cycle after the redirect.
- Stall with a full queue: imem_req deasserts and the queue holds. No entry is lost or duplicated.
- Stall with out_valid=0 has no effect.

Test Plan:
1. Zero-wait streaming: reset release, ack every cycle, mem[a]=a^32'hA5A50000 -> out_valid from cycle 1; out_pc4 = 4,8,12,...; instructions in order; 1 per cycle.
2. Backpressure: stall=1 for 10 cycles from cycle 2 -> count saturates at 4; imem_req=0 while full; on release, contiguous sequence with no gaps or duplicates.
3. Redirect with same-cycle ack: ack for 0x8 and redirect_pc=0x103 in the same cycle -> 0x8 data never appears; next imem_addr=0x100; next out_pc4=0x104.
4. Redirect during wait state: ack delayed 3 cycles, redirect to 0x200 at cycle 1 of the wait -> imem_addr holds old value until ack; that data is dropped; then imem_addr=0x200; second redirect to 0x300 during the hold -> fetch resumes at 0x300.
5. Wrap: redirect_pc=0xFFFFFFFC -> entry out_pc4=0x00000000; next imem_addr=0x00000000.
6. Reset mid-operation: pcrst asserted with 3 entries queued and drop=1 -> next cycle out_valid=0 and imem_req=0; after release, fetch restarts at RESET_PC with the stale ack ignored.
